// File: rtl/sm4_pkg.sv
// rtl/sm4_pkg.sv - SM4 key-schedule constants (FK, CK), FSM state type and round count
package sm4_pkg;

    localparam int SM4_ROUNDS = 32;

    localparam logic [31:0] FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] FK1 = 32'h56AA3350;
    localparam logic [31:0] FK2 = 32'h677D9197;
    localparam logic [31:0] FK3 = 32'hB27022DC;

    // Byte j of CK[i] is (4i+j)*7 mod 256, byte 0 in the MSB; kept as a literal table.
    localparam logic [31:0] CK [SM4_ROUNDS] = '{
        32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
        32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
        32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
        32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
        32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
        32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
        32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
        32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/Transform_for_key_exp.sv
// rtl/Transform_for_key_exp.sv - combinational SM4 key-schedule transform T' (S-box + L')
module Transform_for_key_exp (
    input  logic [31:0] in_i,
    output logic [31:0] out_o
);

    // SM4 S-box, entry 0 in the most significant byte of row 0.
    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic [31:0] sub;

    // Byte-wise substitution followed by the key-schedule linear mix L'(B) = B ^ B<<<13 ^ B<<<23.
    always_comb begin
        sub   = {SBOX[in_i[31:24]], SBOX[in_i[23:16]], SBOX[in_i[15:8]], SBOX[in_i[7:0]]};
        out_o = sub ^ {sub[18:0], sub[31:19]} ^ {sub[8:0], sub[31:9]};
    end

endmodule

// File: rtl/sm4_key_expansion_ctrl.sv
// rtl/sm4_key_expansion_ctrl.sv - SM4 round-key expansion controller; option SM4_KEYEXP_DEC_ORDER_EN adds reversed read order
module sm4_key_expansion_ctrl
    import sm4_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic [4:0]   rd_idx,
`ifdef SM4_KEYEXP_DEC_ORDER_EN
    input  logic         dec,
`endif
    output logic [31:0]  rd_key
);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] k_q [4];
    logic [31:0] k_d [4];
    logic        keys_valid_q, keys_valid_d;
    logic [31:0] rd_key_q;
    logic        rk_we;
    logic [31:0] t_in, t_out, k_new;
    logic [4:0]  eff_idx;

    // Round-key storage is deliberately left out of reset.
    logic [31:0] rk_mem [SM4_ROUNDS];

    assign t_in  = k_q[1] ^ k_q[2] ^ k_q[3] ^ CK[cnt_q];
    assign k_new = k_q[0] ^ t_out;

    Transform_for_key_exp u_tprime (
        .in_i  (t_in),
        .out_o (t_out)
    );

`ifdef SM4_KEYEXP_DEC_ORDER_EN
    assign eff_idx = dec ? (5'd31 - rd_idx) : rd_idx;
`else
    assign eff_idx = rd_idx;
`endif

    // State, counter, K window and keys_valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            keys_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) k_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            keys_valid_q <= keys_valid_d;
            for (int i = 0; i < 4; i++) k_q[i] <= k_d[i];
        end
    end

    // Next-state logic: capture MK^FK on accept, then one T' round per ROUND cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        keys_valid_d = keys_valid_q;
        rk_we        = 1'b0;
        for (int i = 0; i < 4; i++) k_d[i] = k_q[i];
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    k_d[0]       = key_in[127:96] ^ FK0;
                    k_d[1]       = key_in[95:64]  ^ FK1;
                    k_d[2]       = key_in[63:32]  ^ FK2;
                    k_d[3]       = key_in[31:0]   ^ FK3;
                    cnt_d        = '0;
                    keys_valid_d = 1'b0;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                state_d = ROUND;
            end
            ROUND: begin
                rk_we  = 1'b1;
                k_d[0] = k_q[1];
                k_d[1] = k_q[2];
                k_d[2] = k_q[3];
                k_d[3] = k_new;
                // Hold at the terminal count so a finished pass never wraps.
                if (cnt_q == 5'd31) begin
                    keys_valid_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Round-key write port.
    always_ff @(posedge clk) begin
        if (rk_we) rk_mem[cnt_q] <= k_new;
    end

    // Registered read port; a same-cycle write to the read index yields the old word.
    always_ff @(posedge clk) begin
        if (rst) rd_key_q <= '0;
        else     rd_key_q <= rk_mem[eff_idx];
    end

    assign key_ready  = (state_q == IDLE);
    assign busy       = (state_q == LOAD) || (state_q == ROUND);
    assign done       = (state_q == DONE);
    assign keys_valid = keys_valid_q;
    assign rd_key     = rd_key_q;

endmodule
